// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a length-prefixed little-endian
// byte stream and holds the core in reset until the image is complete.
//
// Ports
//   i_clk, i_rst   clock, synchronous active-high reset
//   i_start        pulse: begin a load (honoured in IDLE, DONE, ERROR)
//   i_byte_valid   stream byte valid
//   i_byte         stream byte
//   o_byte_ready   loader accepts a byte this cycle (LEN, DATA)
//   o_imem_we      instr_mem write strobe, one cycle per word
//   o_imem_addr    byte address of the write (word index * 4)
//   o_imem_wdata   assembled instruction word
//   o_busy         high in LEN and DATA
//   o_done         image fully written
//   o_error        header word count exceeds DEPTH_WORDS (sticky)
//   o_cpu_rst      reset request to the core (low only in DONE)
//   o_word_cnt     words written in the current load
module imem_loader #(
    parameter int unsigned DEPTH_WORDS = 2048,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte,
    output logic             o_byte_ready,
    output logic             o_imem_we,
    output logic [31:0]      o_imem_addr,
    output logic [31:0]      o_imem_wdata,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic             o_cpu_rst,
    output logic [CNT_W-1:0] o_word_cnt
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ASM_W  = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_DONE,
        S_ERROR
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [1:0]          byte_cnt;
    logic [ASM_W-1:0]    asm_q;      // first three bytes of the word in flight
    logic [CNT_W-1:0]    len_q;      // header word count
    logic                accept_c;
    logic                last_byte_c;
    logic                start_c;
    logic [WORD_W-1:0]   word_c;

    // Byte handshake and word assembly: the newest byte lands in the top lane.
    always_comb begin
        accept_c    = i_byte_valid && o_byte_ready;
        last_byte_c = accept_c && (byte_cnt == 2'd3);
        word_c      = {i_byte, asm_q};
        start_c     = i_start && ((state == S_IDLE) || (state == S_DONE) ||
                                  (state == S_ERROR));
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start_c) state_next = S_LEN;
            end
            S_LEN: begin
                if (last_byte_c) begin
                    if (word_c == '0)
                        state_next = S_DONE;
                    else if (word_c > WORD_W'(DEPTH_WORDS))
                        state_next = S_ERROR;
                    else
                        state_next = S_DATA;
                end
            end
            S_DATA: begin
                // The last word's write cycle is already spent in DONE.
                if (last_byte_c && ((o_word_cnt + CNT_W'(1)) == len_q))
                    state_next = S_DONE;
            end
            S_DONE, S_ERROR: begin
                if (start_c) state_next = S_LEN;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and registered outputs; status flags follow the next state so
    // they are valid in the same cycle the FSM enters a state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_cnt     <= '0;
            asm_q        <= '0;
            len_q        <= '0;
            o_byte_ready <= 1'b0;
            o_imem_we    <= 1'b0;
            o_imem_addr  <= '0;
            o_imem_wdata <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_error      <= 1'b0;
            o_cpu_rst    <= 1'b1;
            o_word_cnt   <= '0;
        end else begin
            o_imem_we <= 1'b0;

            if (start_c) begin
                byte_cnt   <= '0;
                o_word_cnt <= '0;
            end

            if (accept_c) begin
                asm_q    <= word_c[WORD_W-1:WORD_W-ASM_W];
                byte_cnt <= byte_cnt + 2'd1;
            end

            // Only meaningful when within DEPTH_WORDS; larger counts go to ERROR.
            if (last_byte_c && (state == S_LEN)) begin
                len_q <= CNT_W'(word_c);
            end

            if (last_byte_c && (state == S_DATA)) begin
                o_imem_we    <= 1'b1;
                o_imem_addr  <= WORD_W'(o_word_cnt) << 2;
                o_imem_wdata <= word_c;
                o_word_cnt   <= o_word_cnt + CNT_W'(1);
            end

            o_byte_ready <= (state_next == S_LEN) || (state_next == S_DATA);
            o_busy       <= (state_next == S_LEN) || (state_next == S_DATA);
            o_done       <= (state_next == S_DONE);
            o_error      <= (state_next == S_ERROR);
            o_cpu_rst    <= (state_next != S_DONE);
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of load records plus hand-written corner
// sequences; expected writes come from the generated word list.
module tb_imem_loader;

    localparam int unsigned DEPTH = 2048;
    localparam int unsigned CW    = 16;

    logic          i_clk;
    logic          i_rst;
    logic          i_start;
    logic          i_byte_valid;
    logic [7:0]    i_byte;
    logic          o_byte_ready;
    logic          o_imem_we;
    logic [31:0]   o_imem_addr;
    logic [31:0]   o_imem_wdata;
    logic          o_busy;
    logic          o_done;
    logic          o_error;
    logic          o_cpu_rst;
    logic [CW-1:0] o_word_cnt;

    imem_loader #(.DEPTH_WORDS(DEPTH), .CNT_W(CW)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_start      (i_start),
        .i_byte_valid (i_byte_valid),
        .i_byte       (i_byte),
        .o_byte_ready (o_byte_ready),
        .o_imem_we    (o_imem_we),
        .o_imem_addr  (o_imem_addr),
        .o_imem_wdata (o_imem_wdata),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_error      (o_error),
        .o_cpu_rst    (o_cpu_rst),
        .o_word_cnt   (o_word_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        logic [31:0] hdr;
        int          max_gap;
        bit          exp_done;
        bit          exp_err;
        logic [15:0] exp_cnt;
    } vec_t;

    int          n_pass  = 0;
    int          n_total = 0;
    int          cyc     = 0;
    int          last_acc = 0;
    wr_t         got_q[$];
    wr_t         exp_q[$];
    logic [31:0] wbuf[$];
    vec_t        vecs[7];

    always @(posedge i_clk) cyc <= cyc + 1;

    // Write monitor: every strobe seen between edges is one write.
    always @(negedge i_clk) begin
        if (o_imem_we) got_q.push_back('{o_imem_addr, o_imem_wdata, cyc});
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Present one byte at a negedge and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        i_byte_valid = 1'b1;
        i_byte       = b;
        while (!o_byte_ready && t < 50) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 50) begin
            check("byte accept timeout", 32'(o_byte_ready), 32'd1);
        end else begin
            last_acc = cyc + 1;
        end
        @(negedge i_clk);
        i_byte_valid = 1'b0;
    endtask

    task automatic gap_cycles(input int max_gap, input bit noise);
        int g;
        g = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
        repeat (g) begin
            if (noise && ($urandom_range(2, 0) == 0)) i_start = 1'b1;
            @(negedge i_clk);
            i_start = 1'b0;
        end
    endtask

    // One complete load: start pulse, header, every word in wbuf.
    task automatic run_load(input string tag, input logic [31:0] hdr, input int max_gap,
                            input bit noise, input bit exp_done, input bit exp_err,
                            input logic [15:0] exp_cnt);
        logic [31:0] w;
        int          n;
        got_q.delete();
        exp_q.delete();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check($sformatf("%s busy after start", tag), 32'(o_busy), 32'd1);
        check($sformatf("%s cpu_rst after start", tag), 32'(o_cpu_rst), 32'd1);
        check($sformatf("%s done after start", tag), 32'(o_done), 32'd0);
        for (int i = 0; i < 4; i++) begin
            gap_cycles(max_gap, noise);
            send_byte(hdr[8*i +: 8]);
        end
        for (int k = 0; k < wbuf.size(); k++) begin
            w = wbuf[k];
            for (int j = 0; j < 4; j++) begin
                gap_cycles(max_gap, noise);
                send_byte(w[8*j +: 8]);
            end
            exp_q.push_back('{32'(k * 4), w, last_acc});
        end
        // Cycle right after the final byte: terminal state already visible.
        check($sformatf("%s done", tag), 32'(o_done), 32'(exp_done));
        check($sformatf("%s error", tag), 32'(o_error), 32'(exp_err));
        check($sformatf("%s cpu_rst", tag), 32'(o_cpu_rst), 32'(!exp_done));
        check($sformatf("%s ready", tag), 32'(o_byte_ready), 32'd0);
        check($sformatf("%s busy", tag), 32'(o_busy), 32'd0);
        check($sformatf("%s word_cnt", tag), 32'(o_word_cnt), 32'(exp_cnt));
        repeat (3) @(negedge i_clk);
        check($sformatf("%s write count", tag), 32'(got_q.size()), 32'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s w%0d addr", tag, k), got_q[k].addr, exp_q[k].addr);
            check($sformatf("%s w%0d data", tag, k), got_q[k].data, exp_q[k].data);
            check($sformatf("%s w%0d cycle", tag, k), 32'(got_q[k].cyc), 32'(exp_q[k].cyc));
        end
        check($sformatf("%s error held", tag), 32'(o_error), 32'(exp_err));
    endtask

    task automatic fill_random(input int n);
        wbuf.delete();
        for (int k = 0; k < n; k++) wbuf.push_back($urandom());
    endtask

    task automatic fill_program;
        wbuf.delete();
        wbuf.push_back(32'h0000_0093);
        wbuf.push_back(32'h4000_0113);
        wbuf.push_back(32'h0021_1033);
    endtask

    initial begin
        vecs[0] = '{32'd0,            0, 1'b1, 1'b0, 16'd0};
        vecs[1] = '{32'd1,            2, 1'b1, 1'b0, 16'd1};
        vecs[2] = '{32'd7,            3, 1'b1, 1'b0, 16'd7};
        vecs[3] = '{32'(DEPTH + 1),   1, 1'b0, 1'b1, 16'd0};
        vecs[4] = '{32'h0001_0000,    0, 1'b0, 1'b1, 16'd0};
        vecs[5] = '{32'hFFFF_FFFF,    0, 1'b0, 1'b1, 16'd0};
        vecs[6] = '{32'(DEPTH),       0, 1'b1, 1'b0, 16'(DEPTH)};

        i_rst        = 1'b1;
        i_start      = 1'b0;
        i_byte_valid = 1'b0;
        i_byte       = 8'h00;

        // Reset state.
        repeat (2) @(negedge i_clk);
        check("rst cpu_rst", 32'(o_cpu_rst), 32'd1);
        check("rst we", 32'(o_imem_we), 32'd0);
        check("rst busy", 32'(o_busy), 32'd0);
        check("rst done", 32'(o_done), 32'd0);
        check("rst error", 32'(o_error), 32'd0);
        check("rst ready", 32'(o_byte_ready), 32'd0);
        check("rst word_cnt", 32'(o_word_cnt), 32'd0);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("idle ready", 32'(o_byte_ready), 32'd0);

        // Three-instruction image at full rate.
        fill_program();
        run_load("prog", 32'd3, 0, 1'b0, 1'b1, 1'b0, 16'd3);

        // Table of header boundary cases.
        for (int v = 0; v < 7; v++) begin
            if (vecs[v].exp_err) wbuf.delete();
            else fill_random(int'(vecs[v].exp_cnt));
            run_load($sformatf("vec%0d", v), vecs[v].hdr, vecs[v].max_gap, 1'b0,
                     vecs[v].exp_done, vecs[v].exp_err, vecs[v].exp_cnt);
        end

        // Oversized header, then a restart must clear the error.
        wbuf.delete();
        run_load("err", 32'(DEPTH + 1), 0, 1'b0, 1'b0, 1'b1, 16'd0);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        check("err restart error", 32'(o_error), 32'd0);
        check("err restart busy", 32'(o_busy), 32'd1);
        check("err restart ready", 32'(o_byte_ready), 32'd1);
        check("err restart cpu_rst", 32'(o_cpu_rst), 32'd1);
        for (int i = 0; i < 4; i++) send_byte(8'h00);
        check("err restart empty done", 32'(o_done), 32'd1);

        // Program image again with idle gaps and stray start pulses.
        fill_program();
        run_load("prog gaps", 32'd3, 3, 1'b1, 1'b1, 1'b0, 16'd3);

        // Random images with gaps and start noise.
        for (int r = 0; r < 6; r++) begin
            int n;
            n = int'($urandom_range(20, 1));
            fill_random(n);
            run_load($sformatf("rnd%0d", r), 32'(n), 3, 1'b1, 1'b1, 1'b0, 16'(n));
        end

        // Reset partway through word 0 discards it.
        got_q.delete();
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
        send_byte(8'h03); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'h93); send_byte(8'h00);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        check("midrst busy", 32'(o_busy), 32'd0);
        check("midrst ready", 32'(o_byte_ready), 32'd0);
        check("midrst cpu_rst", 32'(o_cpu_rst), 32'd1);
        check("midrst word_cnt", 32'(o_word_cnt), 32'd0);
        check("midrst no write", 32'(got_q.size()), 32'd0);
        fill_program();
        run_load("after rst", 32'd3, 0, 1'b0, 1'b1, 1'b0, 16'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
